vga_fb_arbiter: RTL and testbench

Single-port frame-buffer arbiter between the VGA scanout path and two pixel writers (draw engine, host). Sits between the xvga timing generator and the frame-buffer BRAM. It prefetches scanout pixels into a small FIFO in raster order and shares the remaining memory slots between the writers. Every clock carries exactly one memory access or an idle slot.

---
 rtl/vga_fb_arbiter_if.sv | 49 ++++
 rtl/vga_fb_arbiter.sv | 138 +++++++++++++
 tb/tb_vga_fb_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_arbiter_if.sv
// Frame-buffer arbiter bus: display stream, two writers, BRAM port.
// slave = arbiter side, master = timing generator / writers / BRAM side.
interface vga_fb_arbiter_if #(
  parameter int AW = 20,
  parameter int DW = 8
);
  logic          frame_sync;
  logic          pix_rd;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          underrun;
  logic          w0_req;
  logic          w1_req;
  logic [AW-1:0] w0_addr;
  logic [AW-1:0] w1_addr;
  logic [DW-1:0] w0_data;
  logic [DW-1:0] w1_data;
  logic          w0_gnt;
  logic          w1_gnt;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  frame_sync, pix_rd,
    input  w0_req, w1_req,
    input  w0_addr, w1_addr,
    input  w0_data, w1_data,
    input  mem_rdata,
    output pix_data, pix_valid, underrun,
    output w0_gnt, w1_gnt,
    output mem_en, mem_we,
    output mem_addr, mem_wdata
  );

  modport master (
    output frame_sync, pix_rd,
    output w0_req, w1_req,
    output w0_addr, w1_addr,
    output w0_data, w1_data,
    output mem_rdata,
    input  pix_data, pix_valid, underrun,
    input  w0_gnt, w1_gnt,
    input  mem_en, mem_we,
    input  mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: scanout prefetch FIFO plus two writers.
// Define VGA_ARB_RR_EN for round-robin writers; default is w0 over w1.
module vga_fb_arbiter #(
  parameter int AW    = 20,
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int NPIX  = 786432
) (
  input  logic clk,
  input  logic rst_n,
  vga_fb_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] HALF = CW'(DEPTH / 2);
  localparam logic [AW-1:0] LAST = AW'(NPIX - 1);

  typedef enum logic [1:0] {
    FLUSH, PRIME, RUN, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] fifo_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] fill;
  logic          inflight_q, inflight_d;
  logic          underrun_q, underrun_d;
  logic [AW-1:0] scan_q, scan_d;
  logic          wreq, do_rd, do_wr, sel1;
  logic          push, pop, empty;

`ifdef VGA_ARB_RR_EN
  logic last_q, last_d;
  assign sel1 = bus.w1_req & (~bus.w0_req | ~last_q);
  assign last_d = do_wr ? sel1 : last_q;
`else
  assign sel1 = ~bus.w0_req;
`endif

  assign fill  = count_q + CW'(inflight_q);
  assign wreq  = bus.w0_req | bus.w1_req;
  assign empty = (count_q == '0);

  always_comb begin
    do_rd = 1'b0;
    do_wr = 1'b0;
    unique case (state_q)
      FLUSH: ;
      PRIME: do_rd = (fill < FULL);
      RUN: begin
        if (fill < HALF)  do_rd = 1'b1;
        else if (wreq)    do_wr = 1'b1;
        else              do_rd = (fill < FULL);
      end
      DONE:  do_wr = wreq;
      default: ;
    endcase
  end

  assign bus.w0_gnt    = do_wr & ~sel1;
  assign bus.w1_gnt    = do_wr & sel1;
  assign bus.mem_en    = do_rd | do_wr;
  assign bus.mem_we    = do_wr;
  assign bus.mem_addr  = do_wr ? (sel1 ? bus.w1_addr : bus.w0_addr)
                       : (do_rd ? scan_q : '0);
  assign bus.mem_wdata = do_wr ? (sel1 ? bus.w1_data : bus.w0_data) : '0;
  assign bus.pix_valid = ~empty;
  assign bus.pix_data  = empty ? '0 : fifo_q[rd_ptr_q];
  assign bus.underrun  = underrun_q;

  // Read data landing in the frame_sync cycle belongs to the old frame.
  assign push = inflight_q & ~bus.frame_sync;
  assign pop  = bus.pix_rd & ~empty;

  always_comb begin
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(push);
    count_d    = count_q + CW'(push) - CW'(pop);
    inflight_d = do_rd;
    scan_d     = (do_rd && scan_q != LAST) ? scan_q + AW'(1) : scan_q;
    underrun_d = underrun_q | (bus.pix_rd & empty);
    state_d    = state_q;
    unique case (state_q)
      FLUSH: state_d = PRIME;
      PRIME: begin
        if (do_rd && scan_q == LAST) state_d = DONE;
        else if (fill == FULL)       state_d = RUN;
      end
      RUN:   if (do_rd && scan_q == LAST) state_d = DONE;
      DONE:  ;
      default: state_d = FLUSH;
    endcase
    if (state_q == FLUSH || bus.frame_sync) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      inflight_d = 1'b0;
      scan_d     = '0;
    end
    if (bus.frame_sync) begin
      state_d    = FLUSH;
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= bus.mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FLUSH;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      underrun_q <= 1'b0;
      scan_q     <= '0;
`ifdef VGA_ARB_RR_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      underrun_q <= underrun_d;
      scan_q     <= scan_d;
`ifdef VGA_ARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: scanout, writers, flush, underrun,
// plus a second instance with a 16-pixel frame for the DONE state.
module tb_vga_fb_arbiter;
  localparam int AW    = 20;
  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  vga_fb_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  vga_fb_arbiter_if #(.AW(AW), .DW(DW)) bus16 ();

  vga_fb_arbiter #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .NPIX(786432)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  vga_fb_arbiter #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .NPIX(16)
  ) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16)
  );

  function automatic logic [DW-1:0] pat(input int a);
    return DW'(a * 37 + 11);
  endfunction

  always_ff @(posedge clk) begin
    if (bus.mem_en && !bus.mem_we)
      bus.mem_rdata <= pat(int'(bus.mem_addr));
  end

  always_ff @(posedge clk) begin
    if (bus16.mem_en && !bus16.mem_we)
      bus16.mem_rdata <= pat(int'(bus16.mem_addr));
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] exp_w1;
    int derr, g, rd_n, pop_n, e;
`ifdef VGA_ARB_RR_EN
    exp_w1 = 3'b010;
`else
    exp_w1 = 3'b000;
`endif
    bus.frame_sync = 0; bus.pix_rd = 0;
    bus.w0_req = 0; bus.w1_req = 0;
    bus.w0_addr = '0; bus.w1_addr = '0;
    bus.w0_data = '0; bus.w1_data = '0;
    bus16.frame_sync = 0; bus16.pix_rd = 0;
    bus16.w0_req = 0; bus16.w1_req = 0;
    bus16.w0_addr = '0; bus16.w1_addr = '0;
    bus16.w0_data = '0; bus16.w1_data = '0;

    // reset: requests and pix_rd held high must not leak through
    step(); bus.w0_req = 1; bus.pix_rd = 1;
    step(); #1;
    chk("rst_pix_data", 32'(bus.pix_data), 0);
    chk("rst_pix_valid", 32'(bus.pix_valid), 0);
    chk("rst_underrun", 32'(bus.underrun), 0);
    chk("rst_gnt", 32'({bus.w0_gnt, bus.w1_gnt}), 0);
    chk("rst_mem_en", 32'(bus.mem_en), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    step(); rst_n = 1; bus.w0_req = 0; bus.pix_rd = 0;
    step(); step();

    // frame 1: prime from address 0
    step(); bus.frame_sync = 1; #1;
    step(); bus.frame_sync = 0; #1;
    chk("flush_mem_en", 32'(bus.mem_en), 0);
    chk("flush_valid", 32'(bus.pix_valid), 0);
    for (int i = 0; i < 8; i++) begin
      step(); #1;
      chk("prime_rd", 32'({bus.mem_en, bus.mem_we}), 2);
      chk("prime_addr", 32'(bus.mem_addr), 32'(i));
      if (i == 1) chk("prime_valid_c2", 32'(bus.pix_valid), 0);
      if (i == 2) begin
        chk("prime_valid_c3", 32'(bus.pix_valid), 1);
        chk("prime_data0", 32'(bus.pix_data), 32'(pat(0)));
      end
    end
    step(); #1;
    chk("prime_full_idle", 32'(bus.mem_en), 0);

    // both writers against a full FIFO
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 0) begin
        bus.w0_req = 1; bus.w0_addr = 20'h100; bus.w0_data = 8'h11;
        bus.w1_req = 1; bus.w1_addr = 20'h200; bus.w1_data = 8'h22;
      end
      #1;
      chk("wr_gnt", 32'({bus.w0_gnt, bus.w1_gnt}),
          exp_w1[i] ? 32'd1 : 32'd2);
      chk("wr_we", 32'({bus.mem_en, bus.mem_we}), 3);
      chk("wr_addr", 32'(bus.mem_addr), exp_w1[i] ? 32'h200 : 32'h100);
      chk("wr_data", 32'(bus.mem_wdata), exp_w1[i] ? 32'h22 : 32'h11);
    end

    // one line of steady scanout with w0 always requesting
    derr = 0; g = 0;
    step(); bus.w1_req = 0; bus.w0_req = 1; bus.pix_rd = 1;
    for (int k = 0; k < 1024; k++) begin
      if (k > 0) step();
      #1;
      if (bus.pix_valid !== 1'b1 || bus.pix_data !== pat(k)) derr++;
      if (bus.w1_gnt) derr++;
      if (bus.w0_gnt) g++;
    end
    step(); bus.pix_rd = 0; bus.w0_req = 0; #1;
    chk("stream_data_errs", 32'(derr), 0);
    chk("stream_w0_gnts", 32'(g), 5);
    chk("stream_underrun", 32'(bus.underrun), 0);

    // frame 2: underrun in PRIME, then frame_sync with a read in flight
    step(); bus.frame_sync = 1; #1;
    step(); bus.frame_sync = 0; #1;
    step(); bus.pix_rd = 1; #1;
    chk("ur_pix_data", 32'(bus.pix_data), 0);
    chk("ur_mem_addr", 32'(bus.mem_addr), 0);
    step(); bus.pix_rd = 0; #1;
    chk("ur_set", 32'(bus.underrun), 1);
    chk("ur_valid", 32'(bus.pix_valid), 0);
    step(); #1;
    chk("ur_ptr_valid", 32'(bus.pix_valid), 1);
    chk("ur_ptr_data", 32'(bus.pix_data), 32'(pat(0)));
    step(); step(); step();
    step(); bus.frame_sync = 1; #1;
    chk("ur_sticky", 32'(bus.underrun), 1);
    chk("fs_rd_addr", 32'(bus.mem_addr), 6);
    chk("fs_valid_before", 32'(bus.pix_valid), 1);
    step(); bus.frame_sync = 0; #1;
    chk("fs_valid_after", 32'(bus.pix_valid), 0);
    chk("fs_ur_clear", 32'(bus.underrun), 0);
    chk("fs_flush_idle", 32'(bus.mem_en), 0);
    step(); #1;
    chk("fs_restart_addr", 32'({bus.mem_en, bus.mem_addr}), 32'h100000);
    chk("fs_no_stale", 32'(bus.pix_valid), 0);
    step(); #1;
    chk("fs_no_stale2", 32'(bus.pix_valid), 0);
    step(); #1;
    chk("fs_first_pix", 32'({bus.pix_valid, bus.pix_data}),
        32'({1'b1, pat(0)}));

    // 16-pixel frame: reads stop after address 15
    rd_n = 0; pop_n = 0; e = 0;
    step(); bus16.frame_sync = 1; #1;
    step(); bus16.frame_sync = 0; bus16.pix_rd = 1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) step();
      #1;
      if (bus16.mem_en && !bus16.mem_we) begin
        if (int'(bus16.mem_addr) != rd_n) e++;
        rd_n++;
      end
      if (bus16.pix_valid && bus16.pix_rd) begin
        if (bus16.pix_data !== pat(pop_n)) e++;
        pop_n++;
      end
      if (bus16.mem_we) e++;
    end
    chk("n16_reads", 32'(rd_n), 16);
    chk("n16_pops", 32'(pop_n), 16);
    chk("n16_errs", 32'(e), 0);
    chk("n16_drained", 32'(bus16.pix_valid), 0);
    step(); bus16.pix_rd = 0;
    bus16.w0_req = 1; bus16.w0_addr = 20'h33; bus16.w0_data = 8'h44; #1;
    chk("done_wr", 32'({bus16.mem_en, bus16.mem_we, bus16.w0_gnt}), 7);
    chk("done_wr_addr", 32'(bus16.mem_addr), 32'h33);
    step(); bus16.w0_req = 0; #1;
    chk("done_idle", 32'(bus16.mem_en), 0);
    step(); bus16.frame_sync = 1; #1;
    step(); bus16.frame_sync = 0; #1;
    step(); #1;
    chk("done_restart", 32'({bus16.mem_en, bus16.mem_we, bus16.mem_addr}),
        32'h200000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
